rmii_tx_framer: RTL and testbench
=================================

Name: rmii_tx_framer

Overview:
- Next-generation RMII transmit framer for the Ethernet path. It runs entirely in the 50 MHz RMII reference clock domain, so there is no 12.5 MHz byte-clock crossing.
- Accepts payload bytes over a valid/ready/last handshake.
- Prepends a parametrised preamble and SFD, optionally appends the FCS, and enforces a parametrised inter-frame gap.
- Supports both 100 Mbit/s and 10 Mbit/s RMII signalling (each dibit held for SLOW_DIV clocks at 10 Mbit/s).

Parameters:
- PREAMBLE_LEN, 7, number of 0x55 bytes sent before the single 0xD5 SFD byte; range 1..15.
- IFG_BYTES, 12, inter-frame gap in byte-times at the frame's speed; range 1..31.
- SLOW_DIV, 10, clocks per dibit in 10 Mbit/s mode; must be at least 2.

Ports:
- clock  in  1  RMII 50 MHz reference clock (PHY_CLK50 net).
- reset_n  in  1  asynchronous reset, active-low.
- speed_10  in  1  1 = 10 Mbit/s, 0 = 100 Mbit/s; sampled only at frame start.
- tx_data  in  8  payload byte.
- tx_valid  in  1  tx_data is valid.
- tx_last  in  1  qualifies tx_data as the final payload byte.
- tx_ready  out  1  framer consumes tx_data this clock.
- active  out  1  busy from frame start until the end of the gap.
- underrun  out  1  one-clock pulse when a mid-frame byte was required but tx_valid was low.
- PHY_TX  out  2  RMII TXD[1:0], registered.
- PHY_TX_EN  out  1  RMII TX_EN, registered.

Behaviour:
- Reset (asynchronous, reset_n low):
  - state = IDLE; PHY_TX = 0, PHY_TX_EN = 0, tx_ready = 0, active = 0, underrun = 0; all counters cleared.
  - A reset mid-frame truncates the frame immediately. No FCS and no gap are sent.
- States: IDLE -> PRE -> DATA -> FCS -> GAP -> IDLE. When FCS is compiled out, DATA goes directly to GAP.
- Timing base:
  - slot counter advances every clock (100M) or every SLOW_DIV clocks (10M).
  - dibit index 0..3 within each byte; bytes are sent LSB dibit first (bits [1:0] first).
- IDLE:
  - tx_ready = 0.
  - When tx_valid = 1: latch speed_10, enter PRE, assert active.
  - PHY_TX_EN rises on the next clock edge, carrying dibit 0 of the first 0x55.
- PRE: send PREAMBLE_LEN x 0x55, then 0xD5.
- Byte fetch rule:
  - tx_ready is combinational and is high for exactly one clock: the last clock of dibit 3 of the SFD or of any non-last payload byte.
  - The byte captured that clock is sent starting on the next clock.
- Underrun:
  - Condition: tx_ready = 1 while tx_valid = 0.
  - Response: pulse underrun, drop PHY_TX_EN on the next edge (frame truncated, no FCS), enter GAP.
- A byte captured with tx_last = 1 ends DATA after it is sent. No further tx_ready pulses occur in that frame.
- GAP:
  - PHY_TX_EN = 0, PHY_TX = 0 for IFG_BYTES x 4 slots at the latched speed.
  - Then IDLE; active falls in the clock GAP exits.
- tx_valid asserted during GAP is ignored until IDLE. A new frame starts no earlier than the first IDLE clock.
- speed_10 changes mid-frame are ignored.
- No minimum-length padding: the upstream MAC pads to 60 bytes.
- Back-to-back: a one-byte frame is legal.

Optional Feature:
- Macro: RMII_TX_FCS_EN.
- Defined:
  - CRC-32 (poly 0x04C11DB7 reflected, init 0xFFFFFFFF, final complement) is computed over payload bytes only.
  - The 4 FCS bytes are sent in state FCS, lowest byte first, LSB dibit first.
- Undefined: no FCS state and no CRC logic; the upstream supplies the FCS as payload.

Decomposition:
- Package rmii_tx_pkg:
  - state encoding (one-hot IDLE/PRE/DATA/FCS/GAP).
  - SFD_BYTE = 8'hD5, PRE_BYTE = 8'h55.
  - CRC_INIT = 32'hFFFFFFFF, CRC_POLY_REFL = 32'hEDB88320, CRC_RESIDUE = 32'hDEBB20E3.
- Sub-module rmii_crc32_byte:
  - Combinational next-CRC for one byte, plus a registered accumulator.
  - clear input at frame start, enable on byte capture.
  - Instantiated only under RMII_TX_FCS_EN.

Test Plan:
- 100M preamble: frame of 3 bytes {0x01, 0x02, 0x03}, defaults, FCS off.
  - PHY_TX_EN high for exactly (8+3)*4 = 44 clocks.
  - First 28 dibits are 01; SFD dibits are 01, 01, 01, 11.
  - Then 01, 00, 00, 00 for 0x01.
  - tx_ready pulses 3 times.
- FCS: payload ASCII "123456789" with RMII_TX_FCS_EN.
  - Bytes after payload are 0x26, 0x39, 0xF4, 0xCB.
  - PHY_TX_EN length = (8+9+4)*4 = 84 clocks.
- 10M mode: speed_10 = 1, 1-byte frame 0xA5.
  - Each dibit is held 10 clocks; PHY_TX_EN high for 360 clocks.
  - Gap is 480 clocks before active falls.
- Underrun: drop tx_valid at the 5th byte fetch of a 10-byte frame.
  - underrun pulses once.
  - PHY_TX_EN falls after exactly 8*4 + 4*4 = 48 clocks with no FCS; gap follows.
- Back-to-back: hold tx_valid high across two 60-byte frames.
  - PHY_TX_EN low for at least 48 clocks between frames.
  - Second frame starts preamble only after active has fallen.
- Reset mid-frame: assert reset_n low during DATA.
  - PHY_TX_EN and active go low asynchronously.
  - After release, the next frame starts cleanly with preamble.

Source files
------------

// File: rtl/rmii_tx_framer_pkg.sv
// rmii_tx_pkg: shared state encoding, framing constants and CRC-32 byte step for the RMII transmit framer.
package rmii_tx_pkg;
    typedef enum logic [4:0] {
        IDLE = 5'b00001,
        PRE  = 5'b00010,
        DATA = 5'b00100,
        FCS  = 5'b01000,
        GAP  = 5'b10000
    } state_t;
    localparam logic [7:0] SFD_BYTE = 8'hD5;
    localparam logic [7:0] PRE_BYTE = 8'h55;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        return c;
    endfunction
endpackage

// File: rtl/rmii_tx_framer_if.sv
// rmii_tx_framer_if: payload byte handshake between the MAC (master) and the framer (slave).
interface rmii_tx_framer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;
    modport master(output tx_data, tx_valid, tx_last, input tx_ready);
    modport slave(input tx_data, tx_valid, tx_last, output tx_ready);
endinterface

// File: rtl/rmii_crc32_byte.sv
// rmii_crc32_byte: reflected CRC-32 accumulator, one byte per enable, cleared at frame start.
module rmii_crc32_byte
    import rmii_tx_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        enable,
    input  logic [7:0]  data,
    output logic [31:0] crc
);
    logic [31:0] crc_next;
    assign crc_next = crc32_byte(crc, data);
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) crc <= CRC_INIT;
        else if (clear) crc <= CRC_INIT;
        else if (enable) crc <= crc_next;
    end
endmodule

// File: rtl/rmii_tx_framer.sv
// rmii_tx_framer: RMII transmit framer (preamble/SFD, payload, gap) at 100M or 10M in the 50 MHz domain.
// Define RMII_TX_FCS_EN to append a CRC-32 FCS after the payload.
module rmii_tx_framer
    import rmii_tx_pkg::*;
#(
    parameter int PREAMBLE_LEN = 7,
    parameter int IFG_BYTES    = 12,
    parameter int SLOW_DIV     = 10
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             speed_10,
    rmii_tx_framer_if.slave  tx,
    output logic             active,
    output logic             underrun,
    output logic [1:0]       PHY_TX,
    output logic             PHY_TX_EN
);
    localparam int DW = $clog2(SLOW_DIV);
`ifdef RMII_TX_FCS_EN
    localparam state_t AFTER_DATA = FCS;
`else
    localparam state_t AFTER_DATA = GAP;
`endif
    state_t state, state_n;
    logic [4:0] cnt, cnt_n;
    logic [1:0] dib, dib_n;
    logic [DW-1:0] div, div_n;
    logic [7:0] cur, cur_n, byte_n;
    logic last, last_n, spd, spd_n, ready, tick, bend, en_n;
    assign tick = ~spd | (div == DW'(SLOW_DIV - 1));
    assign bend = tick & (dib == 2'd3);
    assign ready = bend & ((state == PRE & cnt == 5'(PREAMBLE_LEN)) | (state == DATA & ~last));
    assign tx.tx_ready = ready;
    assign underrun = ready & ~tx.tx_valid;
    assign active = state != IDLE;
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        dib_n = dib;
        div_n = div;
        cur_n = cur;
        last_n = last;
        spd_n = spd;
        if (state != IDLE) begin
            div_n = tick ? '0 : div + DW'(1);
            dib_n = tick ? dib + 2'd1 : dib;
        end
        case (state)
            IDLE: if (tx.tx_valid) begin
                state_n = PRE;
                spd_n = speed_10;
                cnt_n = '0;
                dib_n = '0;
                div_n = '0;
            end
            PRE: if (bend) cnt_n = cnt + 5'd1;
            DATA: if (bend && last) begin
                state_n = AFTER_DATA;
                cnt_n = '0;
            end
`ifdef RMII_TX_FCS_EN
            FCS: if (bend) begin
                state_n = (cnt == 5'd3) ? GAP : FCS;
                cnt_n = (cnt == 5'd3) ? '0 : cnt + 5'd1;
            end
`endif
            GAP: if (bend) begin
                state_n = (cnt == 5'(IFG_BYTES - 1)) ? IDLE : GAP;
                cnt_n = (cnt == 5'(IFG_BYTES - 1)) ? '0 : cnt + 5'd1;
            end
            default: ;
        endcase
        // a missing byte at fetch truncates the frame straight into the gap
        if (ready) begin
            state_n = tx.tx_valid ? DATA : GAP;
            cnt_n = '0;
            cur_n = tx.tx_data;
            last_n = tx.tx_last;
        end
    end
`ifdef RMII_TX_FCS_EN
    logic [31:0] crc;
    rmii_crc32_byte u_crc (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (state == IDLE && tx.tx_valid),
        .enable  (ready && tx.tx_valid),
        .data    (tx.tx_data),
        .crc     (crc)
    );
    assign byte_n = state_n == PRE ? (cnt_n == 5'(PREAMBLE_LEN) ? SFD_BYTE : PRE_BYTE)
                  : state_n == FCS ? ~crc[{cnt_n[1:0], 3'b000} +: 8] : cur_n;
`else
    assign byte_n = state_n == PRE ? (cnt_n == 5'(PREAMBLE_LEN) ? SFD_BYTE : PRE_BYTE) : cur_n;
`endif
    assign en_n = ~(state_n == IDLE || state_n == GAP);
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt <= '0;
            dib <= '0;
            div <= '0;
            cur <= '0;
            last <= 1'b0;
            spd <= 1'b0;
            PHY_TX <= 2'b00;
            PHY_TX_EN <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            dib <= dib_n;
            div <= div_n;
            cur <= cur_n;
            last <= last_n;
            spd <= spd_n;
            PHY_TX <= en_n ? byte_n[{dib_n, 1'b0} +: 2] : 2'b00;
            PHY_TX_EN <= en_n;
        end
    end
endmodule

// File: tb/tb_rmii_tx_framer.sv
// tb_rmii_tx_framer: directed scoreboard bench for rmii_tx_framer (default parameters).
module tb_rmii_tx_framer;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic speed_10 = 1'b0;
    logic active, underrun, PHY_TX_EN;
    logic [1:0] PHY_TX;
    rmii_tx_framer_if tx ();
    rmii_tx_framer dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .speed_10  (speed_10),
        .tx        (tx),
        .active    (active),
        .underrun  (underrun),
        .PHY_TX    (PHY_TX),
        .PHY_TX_EN (PHY_TX_EN)
    );
    always #5 clock = ~clock;
`ifdef RMII_TX_FCS_EN
    localparam int FCS_B = 4;
`else
    localparam int FCS_B = 0;
`endif
    int errors = 0, checks = 0;
    logic [1:0] exp_q[$], obs_q[$];
    int len_q[$];
    int re = 0, ro = 0;
    int rdy_tot = 0, und_tot = 0, run = 0, lowrun = 0, last_gap = 0, post = 0, act_gap = 0, idle_run = 0, last_idle = 0;
    logic [7:0] pay[64];
    int l0, r0, u0;

    always @(negedge clock) begin
        if (tx.tx_ready) rdy_tot++;
        if (underrun) und_tot++;
        if (!active) idle_run++;
        if (PHY_TX_EN) begin
            obs_q.push_back(PHY_TX);
            run++;
            if (lowrun > 0) begin
                last_gap = lowrun;
                last_idle = idle_run;
            end
            lowrun = 0;
            idle_run = 0;
        end else begin
            if (run > 0) len_q.push_back(run);
            run = 0;
            lowrun++;
        end
        if (!PHY_TX_EN && active) post++;
        else if (!active && post > 0) begin
            act_gap = post;
            post = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic push_byte(input logic [7:0] b, input int dv);
        for (int d = 0; d < 4; d++)
            for (int k = 0; k < dv; k++) exp_q.push_back(b[2*d +: 2]);
    endtask

`ifdef RMII_TX_FCS_EN
    function automatic logic [31:0] crc_model(input int n);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c ^= {24'h0, pay[i]};
            for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction
`endif

    task automatic push_frame(input int n, input logic spd, input logic fcs);
        int dv = spd ? 10 : 1;
        for (int i = 0; i < 7; i++) push_byte(8'h55, dv);
        push_byte(8'hD5, dv);
        for (int i = 0; i < n; i++) push_byte(pay[i], dv);
`ifdef RMII_TX_FCS_EN
        if (fcs) begin
            logic [31:0] c = crc_model(n);
            for (int k = 0; k < 4; k++) push_byte(c[8*k +: 8], dv);
        end
`endif
    endtask

    function automatic int flen(input int n, input logic spd, input logic fcs);
        return (8 + n + (fcs ? FCS_B : 0)) * 4 * (spd ? 10 : 1);
    endfunction

    task automatic send(input int n, input logic spd, input int drop, input logic keep);
        int idx = 0;
        speed_10 = spd;
        tx.tx_valid = 1'b1;
        tx.tx_data = pay[0];
        tx.tx_last = (n == 1);
        for (int g = 0; g < 20000 && idx < n && !(drop > 0 && idx == drop); g++) begin
            @(negedge clock);
            if (tx.tx_ready) begin
                @(posedge clock);
                #1;
                idx++;
                if (idx == n && keep) begin
                    tx.tx_data = pay[0];
                    tx.tx_last = (n == 1);
                end else if (idx == n || idx == drop) tx.tx_valid = 1'b0;
                else begin
                    tx.tx_data = pay[idx];
                    tx.tx_last = (idx == n - 1);
                end
            end
        end
        chk("send progress", 32'(idx), 32'(drop > 0 ? drop : n));
    endtask

    task automatic wait_idle(input int bound, input string tag);
        for (int i = 0; i < bound; i++) begin
            @(negedge clock);
            if (!active) break;
        end
        repeat (3) @(negedge clock);
        chk({tag, " idle"}, 32'(active), 32'(0));
    endtask

    task automatic check_stream(input string tag);
        int n_new = exp_q.size() - re;
        chk({tag, " dibit count"}, 32'(obs_q.size() - ro), 32'(n_new));
        for (int i = 0; i < n_new && ro + i < obs_q.size(); i++) begin
            logic ok = obs_q[ro + i] === exp_q[re + i];
            chk($sformatf("%s dibit %0d", tag, i), 32'(obs_q[ro + i]), 32'(exp_q[re + i]));
            if (!ok) break;
        end
        re = exp_q.size();
        ro = obs_q.size();
    endtask

    task automatic snap();
        l0 = len_q.size();
        r0 = rdy_tot;
        u0 = und_tot;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tx.tx_valid = 1'b0;
        tx.tx_data = 8'h00;
        tx.tx_last = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset en", 32'(PHY_TX_EN), 32'(0));
        chk("reset txd", 32'(PHY_TX), 32'(0));
        chk("reset active", 32'(active), 32'(0));
        chk("reset underrun", 32'(underrun), 32'(0));
        chk("reset ready", 32'(tx.tx_ready), 32'(0));
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03;
        snap();
        push_frame(3, 1'b0, 1'b1);
        send(3, 1'b0, 0, 1'b0);
        wait_idle(2000, "t100");
        check_stream("t100");
        chk("t100 en len", 32'(len_q[l0]), 32'(flen(3, 1'b0, 1'b1)));
        chk("t100 ready", 32'(rdy_tot - r0), 32'(3));
        chk("t100 underrun", 32'(und_tot - u0), 32'(0));
        chk("t100 gap", 32'(act_gap), 32'(48));

`ifdef RMII_TX_FCS_EN
        for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);
        snap();
        push_frame(9, 1'b0, 1'b0);
        push_byte(8'h26, 1); push_byte(8'h39, 1); push_byte(8'hF4, 1); push_byte(8'hCB, 1);
        send(9, 1'b0, 0, 1'b0);
        wait_idle(2000, "tfcs");
        check_stream("tfcs");
        chk("tfcs en len", 32'(len_q[l0]), 32'(84));
`endif

        pay[0] = 8'hA5;
        snap();
        push_frame(1, 1'b1, 1'b1);
        send(1, 1'b1, 0, 1'b0);
        wait_idle(5000, "t10");
        check_stream("t10");
        chk("t10 en len", 32'(len_q[l0]), 32'(flen(1, 1'b1, 1'b1)));
        chk("t10 ready", 32'(rdy_tot - r0), 32'(1));
        chk("t10 gap", 32'(act_gap), 32'(480));

        for (int i = 0; i < 10; i++) pay[i] = 8'(i * 7 + 3);
        speed_10 = 1'b0;
        snap();
        push_frame(4, 1'b0, 1'b0);
        send(10, 1'b0, 4, 1'b0);
        wait_idle(2000, "tund");
        check_stream("tund");
        chk("tund en len", 32'(len_q[l0]), 32'(48));
        chk("tund pulses", 32'(und_tot - u0), 32'(1));
        chk("tund ready", 32'(rdy_tot - r0), 32'(5));
        chk("tund gap", 32'(act_gap), 32'(48));

        for (int i = 0; i < 60; i++) pay[i] = 8'($urandom_range(0, 255));
        snap();
        push_frame(60, 1'b0, 1'b1);
        push_frame(60, 1'b0, 1'b1);
        send(60, 1'b0, 0, 1'b1);
        send(60, 1'b0, 0, 1'b0);
        wait_idle(4000, "tb2b");
        check_stream("tb2b");
        chk("tb2b len1", 32'(len_q[l0]), 32'(flen(60, 1'b0, 1'b1)));
        chk("tb2b len2", 32'(len_q[l0 + 1]), 32'(flen(60, 1'b0, 1'b1)));
        chk("tb2b ready", 32'(rdy_tot - r0), 32'(120));
        chk("tb2b gap>=48", 32'(last_gap >= 48), 32'(1));
        chk("tb2b active fell", 32'(last_idle >= 1), 32'(1));

        tx.tx_valid = 1'b1;
        tx.tx_data = 8'h3C;
        tx.tx_last = 1'b0;
        repeat (40) @(posedge clock);
        #2;
        chk("trst en before", 32'(PHY_TX_EN), 32'(1));
        reset_n = 1'b0;
        #1;
        chk("trst en async", 32'(PHY_TX_EN), 32'(0));
        chk("trst active async", 32'(active), 32'(0));
        chk("trst ready", 32'(tx.tx_ready), 32'(0));
        tx.tx_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        chk("trst idle en", 32'(PHY_TX_EN), 32'(0));
        re = exp_q.size();
        ro = obs_q.size();
        pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03;
        snap();
        push_frame(3, 1'b0, 1'b1);
        send(3, 1'b0, 0, 1'b0);
        wait_idle(2000, "tpost");
        check_stream("tpost");
        chk("tpost en len", 32'(len_q[l0]), 32'(flen(3, 1'b0, 1'b1)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
